// File: rtl/maxpool_stream.sv
// ---------------------------------------------------------------------------
// maxpool_stream
//   Streaming max-pool engine. Reduces every WINDOW consecutive accepted beats
//   of LANES parallel DATA_W-bit activations to one maximum per lane.
//   Ties keep the earliest beat (a lane is replaced only on a strictly greater
//   value). The result is registered and appears the cycle after the window's
//   last beat is accepted.
//
// Configuration macro:
//   MAXPOOL_ARGMAX_EN - when defined, out_idx carries the per-lane beat index
//                       of the winning element, registered with out_data.
//                       When undefined, out_idx is tied to 0 and no index
//                       registers exist.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-high
//   clear      in   synchronous abort of the partial window
//   in_valid   in   input beat valid
//   in_ready   out  input beat accepted when in_valid & in_ready
//   in_data    in   LANES*DATA_W, lane k = in_data[k*DATA_W +: DATA_W]
//   out_valid  out  pooled result valid
//   out_ready  in   downstream accepts when out_valid & out_ready
//   out_data   out  LANES*DATA_W per-lane max, same packing as in_data
//   out_idx    out  LANES*$clog2(WINDOW) per-lane argmax beat index
// ---------------------------------------------------------------------------
module maxpool_stream #(
  parameter int DATA_W = 8,
  parameter int WINDOW = 4,
  parameter int LANES  = 1,
  parameter int SIGNED = 0,
  localparam int IDX_W = $clog2(WINDOW)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [LANES*IDX_W-1:0]    out_idx
);

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(WINDOW - 1);

  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic [LANES*DATA_W-1:0] acc_q, acc_d;
  logic                    out_valid_q, out_valid_d;
  logic [LANES*DATA_W-1:0] out_data_q, out_data_d;

  logic                    last_beat;
  logic                    accept;
  logic                    out_fire;
  logic                    complete;
  logic [LANES-1:0]        take;
  logic [LANES*DATA_W-1:0] merged_data;

  // Magnitude compare honouring the configured signedness.
  function automatic logic is_greater(input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b);
    logic gt;
    if (SIGNED != 0) begin
      gt = ($signed(a) > $signed(b));
    end else begin
      gt = (a > b);
    end
    return gt;
  endfunction

  assign last_beat = (cnt_q == LAST_CNT);
  // Only the completing beat can stall, and only behind a blocked result.
  assign in_ready  = !clear && !(last_beat && out_valid_q && !out_ready);
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign complete  = accept && last_beat;

  // Per-lane decision: first beat of a window always loads, later beats
  // replace only on a strictly larger value.
  always_comb begin
    take        = '0;
    merged_data = acc_q;
    for (int k = 0; k < LANES; k++) begin
      if ((cnt_q == '0) ||
          is_greater(in_data[k*DATA_W +: DATA_W], acc_q[k*DATA_W +: DATA_W])) begin
        take[k]                        = 1'b1;
        merged_data[k*DATA_W +: DATA_W] = in_data[k*DATA_W +: DATA_W];
      end else begin
        take[k]                        = 1'b0;
        merged_data[k*DATA_W +: DATA_W] = acc_q[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state for beat counter, accumulator and the output register.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (clear) begin
      cnt_d = '0;
    end else if (accept) begin
      acc_d = merged_data;
      if (last_beat) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + IDX_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end

    // A completion reloads the output even when the old result fires in the
    // same cycle, so back-to-back windows leave no bubble.
    if (complete) begin
      out_valid_d = 1'b1;
      out_data_d  = merged_data;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef MAXPOOL_ARGMAX_EN
  logic [LANES*IDX_W-1:0] idx_acc_q, idx_acc_d;
  logic [LANES*IDX_W-1:0] out_idx_q, out_idx_d;
  logic [LANES*IDX_W-1:0] merged_idx;

  // Winning beat index follows the same take decision as the data.
  always_comb begin
    merged_idx = idx_acc_q;
    for (int k = 0; k < LANES; k++) begin
      if (take[k]) begin
        merged_idx[k*IDX_W +: IDX_W] = cnt_q;
      end else begin
        merged_idx[k*IDX_W +: IDX_W] = idx_acc_q[k*IDX_W +: IDX_W];
      end
    end
  end

  // Next-state for the index accumulator and registered index output.
  always_comb begin
    idx_acc_d = idx_acc_q;
    out_idx_d = out_idx_q;
    if (accept) begin
      idx_acc_d = merged_idx;
    end else begin
      idx_acc_d = idx_acc_q;
    end
    if (complete) begin
      out_idx_d = merged_idx;
    end else begin
      out_idx_d = out_idx_q;
    end
  end

  // Index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_acc_q <= '0;
      out_idx_q <= '0;
    end else begin
      idx_acc_q <= idx_acc_d;
      out_idx_q <= out_idx_d;
    end
  end

  assign out_idx = out_idx_q;
`else
  assign out_idx = '0;
`endif

endmodule

// File: tb/tb_maxpool_stream.sv
module tb_maxpool_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] din;

  always #5 clk = ~clk;

  // Three configurations share the stimulus: 0 = W4/L1/unsigned,
  // 1 = W4/L2/signed, 2 = W9/L1/unsigned.
  logic       rdy0, ov0;
  logic [7:0] od0;
  logic [1:0] oi0;
  logic       rdy1, ov1;
  logic [15:0] od1;
  logic [3:0] oi1;
  logic       rdy2, ov2;
  logic [7:0] od2;
  logic [3:0] oi2;

  maxpool_stream #(.DATA_W(8), .WINDOW(4), .LANES(1), .SIGNED(0)) u_dut0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(din[7:0]), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_idx(oi0));

  maxpool_stream #(.DATA_W(8), .WINDOW(4), .LANES(2), .SIGNED(1)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(din), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_idx(oi1));

  maxpool_stream #(.DATA_W(8), .WINDOW(9), .LANES(1), .SIGNED(0)) u_dut2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy2),
    .in_data(din[7:0]), .out_valid(ov2), .out_ready(out_ready),
    .out_data(od2), .out_idx(oi2));

  logic        rdy_a [3];
  logic        ov_a  [3];
  logic [15:0] od_a  [3];
  logic [7:0]  oi_a  [3];
  assign rdy_a[0] = rdy0;  assign ov_a[0] = ov0;
  assign rdy_a[1] = rdy1;  assign ov_a[1] = ov1;
  assign rdy_a[2] = rdy2;  assign ov_a[2] = ov2;
  assign od_a[0] = {8'h00, od0};  assign oi_a[0] = {6'h00, oi0};
  assign od_a[1] = od1;           assign oi_a[1] = {4'h0, oi1};
  assign od_a[2] = {8'h00, od2};  assign oi_a[2] = {4'h0, oi2};

  int win_c   [3] = '{4, 4, 9};
  int lanes_c [3] = '{1, 2, 1};
  int sgn_c   [3] = '{0, 1, 0};
  int iw_c    [3] = '{2, 2, 4};

  // Behavioural model: list of beats in the open window, one result slot.
  int          cnt_m  [3];
  logic [15:0] beat_m [3][9];
  logic        pend_m [3];
  logic [15:0] cur_d  [3];
  logic [7:0]  cur_i  [3];
  logic [15:0] dlv_d  [3][64];
  logic [7:0]  dlv_i  [3][64];
  int          dlv_n  [3];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_ready(input int d);
    return !clear && !((cnt_m[d] == win_c[d] - 1) && pend_m[d] && !out_ready);
  endfunction

  task automatic model_reset(input int d);
    cnt_m[d]  = 0;
    pend_m[d] = 1'b0;
    cur_d[d]  = '0;
    cur_i[d]  = '0;
  endtask

  task automatic model_pool(input int d);
    logic [15:0] nd;
    logic [7:0]  ni;
    nd = '0;
    ni = '0;
    for (int l = 0; l < lanes_c[d]; l++) begin
      int best;
      int bi;
      logic [7:0] bv;
      best = 0; bi = 0; bv = '0;
      for (int j = 0; j < win_c[d]; j++) begin
        logic [7:0] v;
        int val;
        v   = beat_m[d][j][l*8 +: 8];
        val = (sgn_c[d] != 0) ? int'($signed(v)) : int'(v);
        if (j == 0 || val > best) begin
          best = val; bi = j; bv = v;
        end
      end
      nd[l*8 +: 8] = bv;
      ni = ni | (8'(bi) << (l * iw_c[d]));
    end
    cur_d[d] = nd;
`ifdef MAXPOOL_ARGMAX_EN
    cur_i[d] = ni;
`else
    cur_i[d] = 8'h00;
`endif
  endtask

  task automatic model_step(input int d);
    logic fire, acc, done;
    fire = pend_m[d] && out_ready;
    acc  = in_valid && exp_ready(d);
    done = 1'b0;
    if (fire) begin
      dlv_d[d][dlv_n[d]] = cur_d[d];
      dlv_i[d][dlv_n[d]] = cur_i[d];
      if (dlv_n[d] < 63) dlv_n[d]++;
    end
    if (clear) begin
      cnt_m[d] = 0;
    end else if (acc) begin
      beat_m[d][cnt_m[d]] = din;
      cnt_m[d]++;
      if (cnt_m[d] == win_c[d]) begin
        model_pool(d);
        cnt_m[d] = 0;
        done = 1'b1;
      end
    end
    if (done) pend_m[d] = 1'b1;
    else if (fire) pend_m[d] = 1'b0;
  endtask

  // Per-cycle comparison against the model, then advance the model.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        model_reset(d);
        chk($sformatf("rst_valid%0d", d), 32'(ov_a[d]), 32'd0);
        chk($sformatf("rst_data%0d", d), 32'(od_a[d]), 32'd0);
        chk($sformatf("rst_idx%0d", d), 32'(oi_a[d]), 32'd0);
      end else begin
        chk($sformatf("in_ready%0d", d), 32'(rdy_a[d]), 32'(exp_ready(d)));
        chk($sformatf("out_valid%0d", d), 32'(ov_a[d]), 32'(pend_m[d]));
        chk($sformatf("out_data%0d", d), 32'(od_a[d]), 32'(cur_d[d]));
        chk($sformatf("out_idx%0d", d), 32'(oi_a[d]), 32'(cur_i[d]));
        model_step(d);
      end
    end
  end

  task automatic clear_log();
    for (int d = 0; d < 3; d++) dlv_n[d] = 0;
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    clear    = 1'b1;
    @(posedge clk); #1;
    clear    = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until configuration 0 accepts it.
  task automatic send(input logic [15:0] v);
    int n;
    din      = v;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rdy0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int drops;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; din = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_out_valid", 32'(ov0), 32'd0);
    chk("reset_out_data", 32'(od0), 32'd0);

    // 1: basic window, tie keeps earliest
    do_clear(); clear_log();
    send(16'd3); send(16'd200); send(16'd7); send(16'd200);
    in_valid = 1'b0;
    chk("t1_latency_valid", 32'(ov0), 32'd1);
    chk("t1_latency_data", 32'(od0), 32'd200);
    idle(4);
    chk("t1_count", 32'(dlv_n[0]), 32'd1);
    chk("t1_max", 32'(dlv_d[0][0]), 32'd200);
    chk("t1_signed_max", 32'(dlv_d[1][0]), 32'd7);
`ifdef MAXPOOL_ARGMAX_EN
    chk("t1_idx", 32'(dlv_i[0][0]), 32'd1);
`endif

    // 2: signed versus unsigned compare
    do_clear(); clear_log();
    send(16'h0080); send(16'h00FF); send(16'h0005); send(16'h00FE);
    idle(4);
    chk("t2_unsigned", 32'(dlv_d[0][0]), 32'h00FF);
    chk("t2_signed", 32'(dlv_d[1][0]), 32'h0005);
`ifdef MAXPOOL_ARGMAX_EN
    chk("t2_idx_unsigned", 32'(dlv_i[0][0]), 32'd1);
    chk("t2_idx_signed", 32'(dlv_i[1][0]), 32'd2);
`endif

    // 3: two lanes
    do_clear(); clear_log();
    send(16'h010A); send(16'h0902); send(16'h041E); send(16'h0505);
    idle(4);
    chk("t3_lanes", 32'(dlv_d[1][0]), 32'h091E);
    chk("t3_lane0_only", 32'(dlv_d[0][0]), 32'h001E);
`ifdef MAXPOOL_ARGMAX_EN
    chk("t3_idx", 32'(dlv_i[1][0]), 32'h06);
`endif

    // 4: back-pressure, completing beat stalls
    out_ready = 1'b0;
    do_clear(); clear_log();
    send(16'd5); send(16'd1); send(16'd2); send(16'd3);
    send(16'd9); send(16'd8); send(16'd7);
    din = 16'd6; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_stall_ready", 32'(rdy0), 32'd0);
      chk("t4_hold_data", 32'(od0), 32'd5);
      chk("t4_hold_valid", 32'(ov0), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'd6);
    idle(6);
    chk("t4_count", 32'(dlv_n[0]), 32'd2);
    chk("t4_first", 32'(dlv_d[0][0]), 32'd5);
    chk("t4_second", 32'(dlv_d[0][1]), 32'd9);

    // 5: clear discards partial window
    do_clear(); clear_log();
    send(16'd99); send(16'd99);
    do_clear();
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    idle(4);
    chk("t5_count", 32'(dlv_n[0]), 32'd1);
    chk("t5_after_clear", 32'(dlv_d[0][0]), 32'd4);

    // 5b: async reset with a result pending and a partial window
    out_ready = 1'b0;
    do_clear();
    send(16'd10); send(16'd20); send(16'd30); send(16'd40); send(16'd50);
    in_valid = 1'b0;
    chk("t5_pending_before_rst", 32'(ov0), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid0", 32'(ov0), 32'd0);
    chk("t5_async_valid1", 32'(ov1), 32'd0);
    chk("t5_async_data0", 32'(od0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    idle(2);

    // 6: continuous stream into the 9-beat window
    do_clear(); clear_log();
    drops = 0;
    for (int i = 0; i < 90; i++) begin
      din = 16'(i);
      in_valid = 1'b1;
      @(negedge clk);
      if (!rdy2) drops++;
      @(posedge clk); #1;
    end
    idle(4);
    chk("t6_ready_drops", 32'(drops), 32'd0);
    chk("t6_count", 32'(dlv_n[2]), 32'd10);
    chk("t6_first", 32'(dlv_d[2][0]), 32'd8);
    chk("t6_last", 32'(dlv_d[2][9]), 32'd89);
    chk("t6_w4_count", 32'(dlv_n[0]), 32'd22);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
